// File: rtl/mul_dispatch_pkg.sv
// Shared types for the multiply dispatcher: datapath widths, register index
// type and the dispatcher FSM state encoding.
package fpu_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 4;
   localparam int NREGS  = 16;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [REG_AW-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      RUN          = 2'd0,
      DRAIN        = 2'd1,
      IDLE_DRAINED = 2'd2
   } disp_state_t;

   // One-hot mask selecting a single register of the busy vector.
   function automatic logic [NREGS-1:0] idx_onehot(input reg_idx_t idx);
      return NREGS'(1) << idx;
   endfunction

endpackage

// File: rtl/mul_dispatch_if.sv
// Request, multiplier-issue and multiplier-writeback signals of the dispatcher.
// slave: the dispatcher side.  master: the requester / multiplier side.
interface mul_dispatch_if;
   import fpu_pkg::*;

   logic     req_valid;
   logic     req_ready;
   reg_idx_t req_src1;
   reg_idx_t req_src2;
   reg_idx_t req_dest;

   data_t    mul_operand1;
   data_t    mul_operand2;
   logic     mul_ena;
   reg_idx_t mul_in_dest;

   data_t    mul_result;
   logic     mul_done;
   reg_idx_t mul_out_dest;

   modport slave (
      input  req_valid, req_src1, req_src2, req_dest,
      output req_ready,
      output mul_operand1, mul_operand2, mul_ena, mul_in_dest,
      input  mul_result, mul_done, mul_out_dest
   );

   modport master (
      output req_valid, req_src1, req_src2, req_dest,
      input  req_ready,
      input  mul_operand1, mul_operand2, mul_ena, mul_in_dest,
      output mul_result, mul_done, mul_out_dest
   );

endinterface

// File: rtl/mul_dispatch_scoreboard.sv
// Busy vector and in-flight counter for the multiply dispatcher.
// A writeback clears its busy bit before an issue sets one, so an issue and a
// writeback in the same cycle leave the issued destination marked busy.
module mul_scoreboard
   import fpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             issue,
   input  reg_idx_t         issue_dest,
   input  logic             done,
   input  reg_idx_t         done_dest,
   output logic [NREGS-1:0] busy,
   output logic [3:0]       inflight,
   output logic [3:0]       inflight_next,
   output logic             spurious
);

   logic [NREGS-1:0] busy_next;

   assign spurious = done && !busy[done_dest];

   // Next busy vector: writeback clear first, then issue set.
   always_comb begin
      busy_next = busy;
      if (done) begin
         busy_next = busy_next & ~idx_onehot(done_dest);
      end
      if (issue) begin
         busy_next = busy_next | idx_onehot(issue_dest);
      end
   end

   // Next in-flight count: issue and writeback together cancel; a writeback
   // with nothing in flight saturates at zero.
   always_comb begin
      inflight_next = inflight;
      if (issue && !done) begin
         inflight_next = inflight + 4'd1;
      end else if (done && !issue && (inflight != 4'd0)) begin
         inflight_next = inflight - 4'd1;
      end
   end

   // Scoreboard state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= '0;
         inflight <= '0;
      end else begin
         busy     <= busy_next;
         inflight <= inflight_next;
      end
   end

endmodule

// File: rtl/mul_dispatch.sv
// Multiply dispatcher: holds a 16x32 register file, issues multiplies to an
// external variable-latency multiplier with scoreboard-based hazard checks,
// and retires results on mul_done.  flush_req drains all in-flight work.
//
// Build option: MUL_DISPATCH_BYPASS_EN forwards an active writeback to a
// waiting source operand in the same cycle (not applied to the dest check).
//
// state        | meaning
// RUN          | accepting requests
// DRAIN        | no new issues, waiting for in-flight multiplies to retire
// IDLE_DRAINED | nothing in flight, drained asserted until flush_req drops
module mul_dispatch
   import fpu_pkg::*;
#(
   parameter int MAX_INFLIGHT = 4
) (
   input  logic             clk,
   input  logic             rst,
   mul_dispatch_if.slave    bus,
   input  logic             host_wr_en,
   input  reg_idx_t         host_wr_addr,
   input  data_t            host_wr_data,
   input  reg_idx_t         rd_addr,
   output data_t            rd_data,
   output logic [NREGS-1:0] busy,
   input  logic             flush_req,
   output logic             drained,
   output logic             wb_err
);

   disp_state_t state, state_next;
   data_t       regfile [NREGS];
   logic [3:0]  inflight;
   logic [3:0]  inflight_next;
   logic        spurious;
   logic        issue;
   logic        src1_busy, src2_busy;
   data_t       src1_val, src2_val;

`ifdef MUL_DISPATCH_BYPASS_EN
   logic src1_fwd, src2_fwd;

   assign src1_fwd  = bus.mul_done && (bus.mul_out_dest == bus.req_src1);
   assign src2_fwd  = bus.mul_done && (bus.mul_out_dest == bus.req_src2);
   assign src1_busy = busy[bus.req_src1] && !src1_fwd;
   assign src2_busy = busy[bus.req_src2] && !src2_fwd;
   assign src1_val  = src1_fwd ? bus.mul_result : regfile[bus.req_src1];
   assign src2_val  = src2_fwd ? bus.mul_result : regfile[bus.req_src2];
`else
   assign src1_busy = busy[bus.req_src1];
   assign src2_busy = busy[bus.req_src2];
   assign src1_val  = regfile[bus.req_src1];
   assign src2_val  = regfile[bus.req_src2];
`endif

   // The destination check never forwards, so a WAW against an in-flight
   // multiply always waits for its writeback to retire.
   assign bus.req_ready = !rst && (state == RUN) && !src1_busy && !src2_busy &&
                          !busy[bus.req_dest] && (inflight < 4'(MAX_INFLIGHT));
   assign issue   = bus.req_valid && bus.req_ready;
   assign rd_data = regfile[rd_addr];

   mul_scoreboard u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .issue         (issue),
      .issue_dest    (bus.req_dest),
      .done          (bus.mul_done),
      .done_dest     (bus.mul_out_dest),
      .busy          (busy),
      .inflight      (inflight),
      .inflight_next (inflight_next),
      .spurious      (spurious)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next state and drained flag; DRAIN looks at the post-edge count so drained
   // rises the cycle right after the last writeback.
   always_comb begin
      state_next = state;
      drained    = 1'b0;
      unique case (state)
         RUN: begin
            if (flush_req) state_next = DRAIN;
         end
         DRAIN: begin
            if (inflight_next == 4'd0) state_next = IDLE_DRAINED;
         end
         IDLE_DRAINED: begin
            drained = 1'b1;
            if (!flush_req) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   // Issue register: capture operands and tag on a handshake, one-cycle strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mul_ena      <= 1'b0;
         bus.mul_operand1 <= '0;
         bus.mul_operand2 <= '0;
         bus.mul_in_dest  <= '0;
      end else begin
         bus.mul_ena <= issue;
         if (issue) begin
            bus.mul_operand1 <= src1_val;
            bus.mul_operand2 <= src2_val;
            bus.mul_in_dest  <= bus.req_dest;
         end
      end
   end

   // Register file: the writeback is the later assignment, so it wins over a
   // host write to the same register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regfile[i] <= '0;
         end
      end else begin
         if (host_wr_en) begin
            regfile[host_wr_addr] <= host_wr_data;
         end
         if (bus.mul_done) begin
            regfile[bus.mul_out_dest] <= bus.mul_result;
         end
      end
   end

   // Sticky flag for writebacks to a register that was not marked busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_err <= 1'b0;
      end else if (spurious) begin
         wb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mul_dispatch.sv
module tb_mul_dispatch;

   localparam int MAXI = 4;

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] res;
      int          due;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_wr_en;
   logic [3:0]  host_wr_addr;
   logic [31:0] host_wr_data;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;
   logic [15:0] busy;
   logic        flush_req;
   logic        drained;
   logic        wb_err;

   always #5 clk = ~clk;

   mul_dispatch_if bus ();

   mul_dispatch #(.MAX_INFLIGHT(MAXI)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .host_wr_en   (host_wr_en),
      .host_wr_addr (host_wr_addr),
      .host_wr_data (host_wr_data),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .flush_req    (flush_req),
      .drained      (drained),
      .wb_err       (wb_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   logic [31:0] ref_rf [16];
   bit          ref_busy [16];
   int          ref_infl;
   bit          ref_err;
   int          ref_st;          // 0 run, 1 draining, 2 drained
   bit          exp_ena;
   logic [31:0] exp_op1, exp_op2;
   logic [3:0]  exp_dest;
   pend_t       pq [$];          // multiplier model: outstanding results
   int          cyc;
   int          lat;

   // stimulus for the next cycle
   bit          t_valid, t_hw, t_flush, t_rst;
   logic [3:0]  t_s1, t_s2, t_d, t_ha, t_rd;
   logic [31:0] t_hd;
   bit          man_done;
   logic [3:0]  man_tag;
   logic [31:0] man_res;

   // what happened in the last step (per the model)
   bit g_hs, g_done;
   int g_cyc;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] mulf(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;  // 2.0 * 3.0
      return a * b;
   endfunction

   function automatic logic [15:0] busy_vec();
      logic [15:0] v;
      for (int i = 0; i < 16; i++) v[i] = ref_busy[i];
      return v;
   endfunction

   task automatic reset_ref();
      for (int i = 0; i < 16; i++) begin
         ref_rf[i]   = '0;
         ref_busy[i] = 1'b0;
      end
      ref_infl = 0;
      ref_err  = 1'b0;
      ref_st   = 0;
      exp_ena  = 1'b0;
      exp_op1  = '0;
      exp_op2  = '0;
      exp_dest = '0;
   endtask

   // One clock cycle: drive inputs, check outputs, advance the model.
   task automatic step();
      bit          d, rdy, hs, s1b, s2b;
      logic [3:0]  dt;
      logic [31:0] dr, v1, v2;
      pend_t       p;
      d = 1'b0; dt = '0; dr = '0;
      if (man_done) begin
         d = 1'b1; dt = man_tag; dr = man_res;
      end else if (pq.size() > 0 && pq[0].due <= cyc) begin
         p = pq.pop_front();
         d = 1'b1; dt = p.tag; dr = p.res;
      end
      rst              = t_rst;
      bus.req_valid    = t_valid;
      bus.req_src1     = t_s1;
      bus.req_src2     = t_s2;
      bus.req_dest     = t_d;
      bus.mul_done     = d;
      bus.mul_out_dest = dt;
      bus.mul_result   = dr;
      host_wr_en       = t_hw;
      host_wr_addr     = t_ha;
      host_wr_data     = t_hd;
      rd_addr          = t_rd;
      flush_req        = t_flush;
      #1;
      check("mul_ena", 32'(bus.mul_ena), 32'(exp_ena));
      check("mul_operand1", bus.mul_operand1, exp_op1);
      check("mul_operand2", bus.mul_operand2, exp_op2);
      check("mul_in_dest", 32'(bus.mul_in_dest), 32'(exp_dest));
      check("busy", 32'(busy), 32'(busy_vec()));
      check("drained", 32'(drained), 32'(ref_st == 2));
      check("wb_err", 32'(wb_err), 32'(ref_err));
      check("rd_data", rd_data, ref_rf[t_rd]);

      v1 = ref_rf[t_s1]; s1b = ref_busy[t_s1];
      v2 = ref_rf[t_s2]; s2b = ref_busy[t_s2];
`ifdef MUL_DISPATCH_BYPASS_EN
      if (d && dt == t_s1) begin s1b = 1'b0; v1 = dr; end
      if (d && dt == t_s2) begin s2b = 1'b0; v2 = dr; end
`endif
      rdy = !t_rst && ref_st == 0 && !s1b && !s2b && !ref_busy[t_d] && ref_infl < MAXI;
      check("req_ready", 32'(bus.req_ready), 32'(rdy));

      hs = t_valid && rdy;
      g_hs = hs; g_done = d; g_cyc = cyc;
      if (t_rst) begin
         reset_ref();
      end else begin
         exp_ena = hs;
         if (hs) begin
            exp_op1 = v1; exp_op2 = v2; exp_dest = t_d;
            p.tag = t_d; p.res = mulf(v1, v2); p.due = cyc + 1 + lat;
            pq.push_back(p);
         end
         if (d && !ref_busy[dt]) ref_err = 1'b1;
         if (t_hw) ref_rf[t_ha] = t_hd;
         if (d) begin ref_rf[dt] = dr; ref_busy[dt] = 1'b0; end
         if (hs) ref_busy[t_d] = 1'b1;
         if (hs && !d) ref_infl++;
         else if (d && !hs && ref_infl > 0) ref_infl--;
         case (ref_st)
            0: if (t_flush) ref_st = 1;
            1: if (ref_infl == 0) ref_st = 2;
            2: if (!t_flush) ref_st = 0;
            default: ref_st = 0;
         endcase
      end
      cyc++;
      man_done = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int k, first_done, done_c, iss_c, nd;
      int iss [5];
      lat = 4; cyc = 0; man_done = 1'b0; man_tag = '0; man_res = '0;
      t_valid = 0; t_hw = 0; t_flush = 0; t_rst = 1;
      t_s1 = '0; t_s2 = '0; t_d = '0; t_ha = '0; t_rd = '0; t_hd = '0;
      rst = 1'b1; bus.req_valid = 1'b0; bus.req_src1 = '0; bus.req_src2 = '0; bus.req_dest = '0;
      bus.mul_done = 1'b0; bus.mul_out_dest = '0; bus.mul_result = '0;
      host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0; rd_addr = '0; flush_req = 1'b0;
      for (int i = 0; i < 5; i++) iss[i] = -1;
      @(posedge clk); #1;
      reset_ref();
      step();                                   // reset held: outputs and ready low
      t_rst = 0;

      // basic issue and writeback
      t_hw = 1; t_ha = 4'd1; t_hd = 32'h40000000; step();
      t_ha = 4'd2; t_hd = 32'h40400000; step();
      t_hw = 0;
      t_valid = 1; t_s1 = 4'd1; t_s2 = 4'd2; t_d = 4'd3; step();
      t_valid = 0;
      check("t1_mul_ena", 32'(bus.mul_ena), 32'd1);
      check("t1_op1", bus.mul_operand1, 32'h40000000);
      check("t1_op2", bus.mul_operand2, 32'h40400000);
      check("t1_in_dest", 32'(bus.mul_in_dest), 32'd3);
      check("t1_busy3_set", 32'(busy[3]), 32'd1);
      for (int i = 0; i < 20 && busy[3] !== 1'b0; i++) step();
      t_rd = 4'd3; step();
      check("t1_rd3", rd_data, 32'h40C00000);
      check("t1_busy3_clr", 32'(busy[3]), 32'd0);

      // RAW stall on an in-flight destination
      t_valid = 1; t_s1 = 4'd1; t_s2 = 4'd2; t_d = 4'd3; step();
      t_s1 = 4'd3; t_s2 = 4'd1; t_d = 4'd4;
      done_c = -1; iss_c = -1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (g_done && done_c < 0) done_c = g_cyc;
         if (g_hs) begin iss_c = g_cyc; break; end
      end
      t_valid = 0;
`ifdef MUL_DISPATCH_BYPASS_EN
      check("t2_issue_cycle", 32'(iss_c), 32'(done_c));
`else
      check("t2_issue_cycle", 32'(iss_c), 32'(done_c + 1));
`endif
      check("t2_fwd_op1", bus.mul_operand1, 32'h40C00000);
      for (int i = 0; i < 40 && (pq.size() > 0 || busy !== 16'h0); i++) step();
      check("t2_idle_busy", 32'(busy), 32'd0);

      // in-flight limit
      lat = 8; k = 0; first_done = -1;
      for (int i = 0; i < 60 && k < 5; i++) begin
         t_valid = 1; t_s1 = 4'd1; t_s2 = 4'd2; t_d = 4'(8 + k);
         step();
         if (g_done && first_done < 0) first_done = g_cyc;
         if (g_hs) begin iss[k] = g_cyc; k++; end
      end
      t_valid = 0;
      check("t3_issued", 32'(k), 32'd5);
      check("t3_four_before_done", 32'(iss[3] < first_done), 32'd1);
      check("t3_fifth_after_done", 32'(iss[4]), 32'(first_done + 1));
      for (int i = 0; i < 60 && (pq.size() > 0 || busy !== 16'h0); i++) step();

      // drain with two in flight
      lat = 5;
      t_valid = 1; t_s1 = 4'd1; t_s2 = 4'd2; t_d = 4'd5; step();
      t_d = 4'd6; step();
      t_valid = 0; t_flush = 1; step();
      t_valid = 1; t_d = 4'd7; nd = 0;
      for (int i = 0; i < 40 && nd < 2; i++) begin
         step();
         if (g_done) nd++;
      end
      check("t4_drained", 32'(drained), 32'd1);
      check("t4_ready_low", 32'(bus.req_ready), 32'd0);
      t_valid = 0; t_flush = 0; step();
      check("t4_run_not_drained", 32'(drained), 32'd0);
      t_valid = 1; step();
      t_valid = 0;
      check("t4_resume_issue", 32'(bus.mul_ena), 32'd1);
      for (int i = 0; i < 40 && (pq.size() > 0 || busy !== 16'h0); i++) step();

      // spurious writeback, same-cycle conflicts
      man_done = 1; man_tag = 4'd5; man_res = 32'hDEADBEEF; t_rd = 4'd5; step();
      check("t5_wb_err", 32'(wb_err), 32'd1);
      check("t5_r5", rd_data, 32'hDEADBEEF);
      step(); step();
      check("t5_wb_err_sticky", 32'(wb_err), 32'd1);
      t_hw = 1; t_ha = 4'd7; t_hd = 32'h11111111;
      man_done = 1; man_tag = 4'd7; man_res = 32'h77777777; t_rd = 4'd7; step();
      check("t5_conflict_r7", rd_data, 32'h77777777);
      t_ha = 4'd8; t_hd = 32'h88888888;
      man_done = 1; man_tag = 4'd9; man_res = 32'h99999999; t_rd = 4'd8; step();
      t_hw = 0;
      check("t5_host_r8", rd_data, 32'h88888888);
      t_rd = 4'd9; step();
      check("t5_wb_r9", rd_data, 32'h99999999);

      // reset with three in flight
      lat = 10;
      t_valid = 1; t_s1 = 4'd1; t_s2 = 4'd2; t_d = 4'd10; step();
      t_d = 4'd11; step();
      t_d = 4'd12; step();
      t_valid = 0; t_rst = 1; step();
      check("t6_mul_ena", 32'(bus.mul_ena), 32'd0);
      check("t6_op1", bus.mul_operand1, 32'd0);
      check("t6_op2", bus.mul_operand2, 32'd0);
      check("t6_in_dest", 32'(bus.mul_in_dest), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_wb_err", 32'(wb_err), 32'd0);
      check("t6_drained", 32'(drained), 32'd0);
      check("t6_ready", 32'(bus.req_ready), 32'd0);
      t_rst = 0;
      for (int i = 0; i < 30 && pq.size() > 0; i++) step();
      step();
      check("t6_late_done_spurious", 32'(wb_err), 32'd1);
      t_rst = 1; step();
      pq.delete();
      t_rst = 0; step();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         t_valid = ($urandom_range(0, 9) < 6);
         t_s1    = 4'($urandom_range(0, 15));
         t_s2    = 4'($urandom_range(0, 15));
         t_d     = 4'($urandom_range(0, 15));
         t_hw    = ($urandom_range(0, 9) == 0);
         t_ha    = 4'($urandom_range(0, 15));
         t_hd    = $urandom;
         t_rd    = 4'($urandom_range(0, 15));
         if (!t_flush) t_flush = ($urandom_range(0, 49) == 0);
         else          t_flush = ($urandom_range(0, 9) != 0);
         lat     = $urandom_range(1, 6);
         step();
      end
      t_valid = 0; t_flush = 0; t_hw = 0;
      for (int i = 0; i < 100 && pq.size() > 0; i++) step();
      step();
      check("rand_final_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_dispatch.md
MUL_DISPATCH -- requirements
Module: mul_dispatch

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of multiplies issued but not yet written back (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: an instruction request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the request can be accepted this cycle.
REQ-006 SHALL have ports req_src1, req_src2 and req_dest, input, 4 bits each: register indices.
REQ-007 SHALL have ports mul_operand1 and mul_operand2, output, 32 bits each: operands sent to the multiplier.
REQ-008 SHALL have port mul_ena, output, 1 bit: issue strobe to the multiplier.
REQ-009 SHALL have port mul_in_dest, output, 4 bits: destination tag sent with the issue.
REQ-010 SHALL have ports mul_result (input, 32 bits), mul_done (input, 1 bit) and mul_out_dest (input, 4 bits): the multiplier's writeback.
REQ-011 SHALL have ports host_wr_en (input, 1 bit), host_wr_addr (input, 4 bits) and host_wr_data (input, 32 bits): register preload.
REQ-012 SHALL have ports rd_addr (input, 4 bits) and rd_data (output, 32 bits): combinational register read.
REQ-013 SHALL have port busy, output, 16 bits: scoreboard, one bit per register.
REQ-014 SHALL have ports flush_req (input, 1 bit) and drained (output, 1 bit): drain handshake.
REQ-015 SHALL have port wb_err, output, 1 bit: sticky flag for a spurious writeback.

Function
REQ-016 SHALL hold a 16x32 register file, a 16-bit busy vector and a 4-bit in-flight counter.
REQ-017 SHALL compute req_ready = (state==RUN) && !busy[src1] && !busy[src2] && !busy[dest] && (inflight < MAX_INFLIGHT).
REQ-018 SHALL, on a handshake (req_valid && req_ready), register mul_operand1/2 from regfile[src1]/[src2] and mul_in_dest from dest, assert mul_ena for exactly one cycle on the next cycle, set busy[dest] and increment inflight.
REQ-019 SHALL, when there is no handshake, drive mul_ena to 0 and hold mul_operand1/2 and mul_in_dest.
REQ-020 SHALL allow back-to-back issues, at most one per cycle.
REQ-021 SHALL not depend on a fixed multiplier latency; completion is signalled only by mul_done.
REQ-022 SHALL, on mul_done, write regfile[mul_out_dest] <= mul_result, clear busy[mul_out_dest] and decrement inflight.
REQ-023 SHALL leave inflight unchanged on a cycle with both an issue and a mul_done.
REQ-024 SHALL treat mul_done with busy[mul_out_dest]==0 as spurious: still write the register, set wb_err (cleared only by reset), and saturate inflight at 0.
REQ-025 SHALL let the mul_done write win over host_wr_en when both target the same address in the same cycle; writes to different addresses SHALL both occur.
REQ-026 SHALL implement FSM states RUN, DRAIN and IDLE_DRAINED:
- RUN -> DRAIN on flush_req.
- DRAIN -> IDLE_DRAINED when inflight==0 (immediately if already 0).
- IDLE_DRAINED -> RUN when flush_req deasserts.
REQ-027 SHALL assert drained only in IDLE_DRAINED, and keep req_ready low in DRAIN and IDLE_DRAINED.
REQ-028 SHALL, in DRAIN, keep processing writebacks normally.

Reset
REQ-029 SHALL, while rst is high, clear:
- the regfile, busy and inflight;
- mul_ena, mul_operand1/2 and mul_in_dest;
- wb_err and drained;
- the FSM, to RUN.
REQ-030 SHALL take rst precedence over every simultaneous event.
REQ-031 SHALL hold req_ready low while rst is high.
REQ-032 SHALL, after a reset that occurs mid-operation, treat any later mul_done as spurious per REQ-024.

Configuration
REQ-033 SHALL, with MUL_DISPATCH_BYPASS_EN defined, treat a source equal to mul_out_dest during an active mul_done as not busy, and take that operand from mul_result.
REQ-034 SHALL not apply the bypass of REQ-033 to the dest/WAW check.
REQ-035 SHALL, without MUL_DISPATCH_BYPASS_EN, stall such a request one cycle until the busy bit is clear.

Structure
REQ-036 SHALL place DATA_W=32, REG_AW=4, NREGS=16 and the FSM state enum in the shared package fpu_pkg.
REQ-037 SHALL implement the busy vector and in-flight counter in sub-module mul_scoreboard.

Verification
REQ-038 Basic issue and writeback (multiplier model with 4-cycle latency):
- Stimulus: host-write r1=0x40000000, r2=0x40400000; issue src1=1, src2=2, dest=3.
- Response: the next cycle shows mul_ena=1 with operands 0x40000000/0x40400000, mul_in_dest=3 and busy[3]=1.
- Then, after the model returns mul_done with 0x40C00000, tag 3: rd_addr=3 reads 0x40C00000 and busy[3]=0.
REQ-039 RAW stall: issue dest=3, then immediately request src1=3 -> req_ready=0 until writeback; without the macro, issue occurs one cycle after mul_done; with the macro, issue occurs in the mul_done cycle with operand 0x40C00000.
REQ-040 In-flight limit: five independent requests back-to-back with MAX_INFLIGHT=4 -> four issues, fifth stalled until the first mul_done.
REQ-041 Drain: flush_req asserted with 2 in flight -> req_ready=0, drained=1 the cycle after the second mul_done; flush_req deasserted -> state RUN.
REQ-042 Error and conflict cases:
- Spurious done: mul_done tag 5 with busy[5]=0 -> r5 written and wb_err=1 sticky.
- Same-cycle conflict: host write and mul_done to r7 together -> r7 holds mul_result.
- Reset mid-run: rst during 3 in flight -> all outputs 0 and busy=0 the next cycle.
